uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver paired with the TX transmitter.
//  - Frame: 1 start bit (0), SIZE data bits LSB first, 1 stop bit (1). No parity. Line idles high.
//  - Oversamples RXD at CLKS_PER_BIT clocks per bit and recovers bits by mid-bit sampling.
//  - Presents each received word on RXDATA with a ready/ack handshake.
//  - Flags framing and overrun errors. Sits between the serial pin and the host-side consumer.
// PARAMETERS
//  SIZE          8   data bits per frame (>=1)
//  CLKS_PER_BIT  16  RXC cycles per serial bit (>=4); sample point = CLKS_PER_BIT/2 (integer divide)
// PORTS
//  RXC      in   1     receiver clock; all state changes on rising edge
//  RST_N    in   1     asynchronous, active-low reset
//  RXD      in   1     serial input, asynchronous to RXC
//  RX_ACK   in   1     consumer has taken RXDATA; clears RX_RDY and RX_OVR
//  RXDATA   out  SIZE  last correctly framed word
//  RX_RDY   out  1     RXDATA holds an unacknowledged word
//  RX_BUSY  out  1     a frame is being received (FSM not IDLE)
//  RX_FERR  out  1     one-cycle pulse: stop bit sampled 0
//  RX_OVR   out  1     sticky: a word was overwritten before RX_ACK
// BEHAVIOUR
//  Reset (RST_N=0, asynchronous):
//   - RXDATA=0, RX_RDY=0, RX_BUSY=0, RX_FERR=0, RX_OVR=0.
//   - Synchronizer flops=1, FSM=IDLE, counters=0.
//   - A reset mid-frame abandons the frame; nothing is delivered.
//  Input synchronizer:
//   - RXD passes through 2 flops; rxd_s is the synced value. All decisions use rxd_s.
//  Bit timing:
//   - cnt counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
//   - A "sample" occurs when cnt==CLKS_PER_BIT-1, except in START.
//  FSM states and transitions:
//   - IDLE:  rxd_s==0 -> START, cnt=0.
//   - START: at cnt==CLKS_PER_BIT/2-1, sample rxd_s.
//            1 -> IDLE (false start, nothing flagged).
//            0 -> DATA, cnt=0, bit_idx=0.
//            This re-centres the sample point at mid-bit.
//   - DATA:  on each sample, shift rxd_s into shreg[bit_idx] (LSB first).
//            After bit_idx==SIZE-1 -> STOP; otherwise bit_idx++.
//   - STOP:  on sample:
//            rxd_s==1 -> RXDATA<=shreg, RX_RDY<=1, -> IDLE.
//            rxd_s==0 -> RX_FERR=1 for one cycle; RXDATA and RX_RDY unchanged; -> BREAK.
//   - BREAK: wait for rxd_s==1, then -> IDLE. A held-low line yields exactly one RX_FERR.
//  RX_BUSY = (state != IDLE), registered with the state.
//  Latency: RX_RDY rises on the clock edge that samples the stop bit (mid stop bit).
//   Back-to-back frames with a single stop bit are received without loss.
//  Handshake and boundary cases:
//   - RX_ACK while RX_RDY=1: next cycle RX_RDY=0, RX_OVR=0.
//   - RX_ACK while RX_RDY=0: no effect.
//   - Good frame completes while RX_RDY=1 and no RX_ACK that cycle:
//     RXDATA overwritten, RX_RDY stays 1, RX_OVR<=1.
//   - Good frame completes in the same cycle as RX_ACK:
//     RXDATA <= new word, RX_RDY stays 1, RX_OVR<=0 (no overrun).
//   - Framing error never sets RX_OVR.
// STRUCTURE
//  Package uart_pkg:
//   - typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t.
//   - Shared frame constants: START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
//  One sub-module uart_sync2: 2-flop synchronizer with reset value parameter (1 here).
//  Bit-timing counter, bit index, shift register and FSM stay inline.
// TESTING (CLKS_PER_BIT=16, SIZE=8, RXC period 10 ns; TX side driven bit-by-bit by the bench)
//  1 Frame 0xA5, good stop bit -> RXDATA=0xA5, RX_RDY=1, RX_FERR never 1, RX_OVR=0;
//    RX_ACK -> RX_RDY=0.
//  2 RXD low for 3 clocks, then high -> RX_BUSY pulses, returns to IDLE, RX_RDY stays 0,
//    no RX_FERR.
//  3 Frame 0x3C with stop bit 0, line held low 40 bits -> one 1-cycle RX_FERR, RX_RDY=0,
//    RX_BUSY=1 until line high.
//  4 Frames 0x55 then 0xAA, no RX_ACK -> RXDATA=0xAA, RX_RDY=1, RX_OVR=1;
//    RX_ACK clears both.
//  5 RST_N low during data bit 4 of 0x81 -> all outputs 0 asynchronously;
//    next frame 0x0F -> RXDATA=0x0F.
//  6 Back-to-back 0x00, 0xFF (one stop bit each, RX_ACK pulsed on each RX_RDY) -> both
//    delivered in order, RX_OVR=0; ACK coincident with completion keeps RX_RDY=1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state type and frame-level constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous single-bit input
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with ready/ack handshake, framing and overrun flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int SIZE         = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            i_rxc,
    input  logic            i_rst_n,
    input  logic            i_rxd,
    input  logic            i_rx_ack,
    output logic [SIZE-1:0] o_rxdata,
    output logic            o_rx_rdy,
    output logic            o_rx_busy,
    output logic            o_rx_ferr,
    output logic            o_rx_ovr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

    logic w_rxd_s;
    logic w_sample;

    rx_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [SIZE-1:0]    r_shreg;
    logic [SIZE-1:0]    r_rxdata;
    logic               r_rdy;
    logic               r_busy;
    logic               r_ferr;
    logic               r_ovr;

    uart_sync2 #(.RESET_VAL(IDLE_LEVEL)) u_sync (
        .i_clk   (i_rxc),
        .i_rst_n (i_rst_n),
        .i_d     (i_rxd),
        .o_q     (w_rxd_s)
    );

    assign w_sample = (r_cnt == CNT_LAST);

    always_ff @(posedge i_rxc or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_rxdata  <= '0;
            r_rdy     <= 1'b0;
            r_busy    <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            if (i_rx_ack && r_rdy) begin
                r_rdy <= 1'b0;
                r_ovr <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_rxd_s == START_BIT) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                // Half-bit check both rejects glitches and re-centres later samples at mid-bit.
                START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (w_rxd_s != START_BIT) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_cnt              <= '0;
                        r_shreg[r_bit_idx] <= w_rxd_s;
                        if (r_bit_idx == IDX_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // An ACK landing on the completion edge consumed the old word, so no overrun.
                STOP: begin
                    if (w_sample) begin
                        r_cnt <= '0;
                        if (w_rxd_s == STOP_BIT) begin
                            r_rxdata <= r_shreg;
                            r_rdy    <= 1'b1;
                            r_ovr    <= r_rdy && !i_rx_ack;
                            r_state  <= IDLE;
                            r_busy   <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (w_rxd_s == IDLE_LEVEL) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rxdata  = r_rxdata;
    assign o_rx_rdy  = r_rdy;
    assign o_rx_busy = r_busy;
    assign o_rx_ferr = r_ferr;
    assign o_rx_ovr  = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;

    localparam int SIZE = 8;
    localparam int CPB  = 16;

    logic            clk;
    logic            rst_n;
    logic            rxd;
    logic            rx_ack;
    logic [SIZE-1:0] rxdata;
    logic            rx_rdy;
    logic            rx_busy;
    logic            rx_ferr;
    logic            rx_ovr;

    int n_tests;
    int n_fail;
    int ferr_cnt;
    bit busy_seen;

    uart_rx #(.SIZE(SIZE), .CLKS_PER_BIT(CPB)) dut (
        .i_rxc     (clk),
        .i_rst_n   (rst_n),
        .i_rxd     (rxd),
        .i_rx_ack  (rx_ack),
        .o_rxdata  (rxdata),
        .o_rx_rdy  (rx_rdy),
        .o_rx_busy (rx_busy),
        .o_rx_ferr (rx_ferr),
        .o_rx_ovr  (rx_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_ferr) ferr_cnt <= ferr_cnt + 1;
        if (rx_busy) busy_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [SIZE-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < SIZE; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic wait_rdy(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (rx_rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    logic [SIZE-1:0] m_data;
    logic            m_rdy;
    logic            m_ovr;
    int              ferr_base;
    bit              ok;

    initial begin
        n_tests = 0; n_fail = 0; ferr_cnt = 0; busy_seen = 1'b0;
        rst_n = 1'b0; rxd = 1'b1; rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rxdata", 32'(rxdata), 0);
        chk("reset_flags", {rx_rdy, rx_busy, rx_ferr, rx_ovr}, 0);
        rst_n = 1'b1;
        idle(8);

        // 1: good frame, then ACK
        ferr_base = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        idle(4);
        chk("t1_data", 32'(rxdata), 32'hA5);
        chk("t1_rdy_ovr", {rx_rdy, rx_ovr}, 2'b10);
        chk("t1_ferr", ferr_cnt - ferr_base, 0);
        pulse_ack();
        chk("t1_ack_rdy", rx_rdy, 0);

        // 2: 3-clock glitch is a false start
        busy_seen = 1'b0;
        ferr_base = ferr_cnt;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * CPB);
        chk("t2_busy_seen", busy_seen, 1);
        chk("t2_idle", {rx_busy, rx_rdy}, 0);
        chk("t2_ferr", ferr_cnt - ferr_base, 0);

        // 3: bad stop bit, line held low for 40 bits
        ferr_base = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < SIZE; i++) send_bit(((8'h3C >> i) & 8'h1) != 0);
        rxd = 1'b0;
        repeat (41 * CPB) @(negedge clk);
        chk("t3_ferr_once", ferr_cnt - ferr_base, 1);
        chk("t3_busy_low", rx_busy, 1);
        chk("t3_rdy", rx_rdy, 0);
        chk("t3_data_kept", 32'(rxdata), 32'hA5);
        idle(6);
        chk("t3_busy_released", rx_busy, 0);

        // 4: overrun
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        idle(4);
        chk("t4_data", 32'(rxdata), 32'hAA);
        chk("t4_rdy_ovr", {rx_rdy, rx_ovr}, 2'b11);
        pulse_ack();
        chk("t4_ack_clear", {rx_rdy, rx_ovr}, 0);

        // 5: asynchronous reset during data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h81 >> i) & 8'h1) != 0);
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_rxdata", 32'(rxdata), 0);
        chk("t5_async_flags", {rx_rdy, rx_busy, rx_ferr, rx_ovr}, 0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(CPB);
        send_frame(8'h0F, 1'b1);
        idle(4);
        chk("t5_after_data", 32'(rxdata), 32'h0F);
        pulse_ack();

        // 6: back-to-back frames, ACK coincident with second completion
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                idle(2 * CPB);
            end
            begin
                wait_rdy(400, ok);
                chk("t6_first_seen", ok, 1);
                chk("t6_first_data", 32'(rxdata), 32'h00);
                repeat (10 * CPB - 1) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                chk("t6_second_data", 32'(rxdata), 32'hFF);
                chk("t6_rdy_kept_no_ovr", {rx_rdy, rx_ovr}, 2'b10);
            end
        join
        pulse_ack();
        chk("t6_final", {rx_rdy, rx_ovr}, 0);

        // randomized frames against the frame-level model
        m_data = 8'h0F;
        m_data = 8'hFF;
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            logic [SIZE-1:0] d;
            logic            good;
            d = SIZE'($urandom);
            good = ($urandom_range(0, 3) != 0);
            ferr_base = ferr_cnt;
            send_frame(d, good);
            idle(2 * CPB);
            if (good) begin
                m_ovr  = m_rdy;
                m_rdy  = 1'b1;
                m_data = d;
            end
            chk("rnd_data", 32'(rxdata), 32'(m_data));
            chk("rnd_rdy_ovr", {rx_rdy, rx_ovr}, {m_rdy, m_ovr});
            chk("rnd_ferr", ferr_cnt - ferr_base, good ? 0 : 1);
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                m_rdy = 1'b0;
                m_ovr = 1'b0;
                chk("rnd_ack", {rx_rdy, rx_ovr}, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
